dm_wait_responder: RTL and testbench



---
 rtl/dm_wait_responder.sv | 63 ++++++
 tb/tb_dm_wait_responder.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/dm_wait_responder.sv
// dm_wait_responder: fixed-latency data-memory responder that stalls the MIPS pipeline via busy.
// Each access is tagged by its pc, so a request held across stall cycles is serviced once.
module dm_wait_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        busy
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [3:0]            r_be;
  logic [31:0]           r_last_pc;
  logic [31:0]           r_pc;
  logic [31:0]           r_wdata;
  logic [31:0]           r_rdata;
  logic [ADDR_WIDTH-1:0] r_word;
  logic                  r_wr;
  logic [31:0]           r_mem [2**ADDR_WIDTH];
  logic                  w_start;
  logic                  w_commit;
  logic                  w_unused;
  assign w_start  = r_state == IDLE && (memread || memwrite) && pc != r_last_pc;
  assign w_commit = r_state == ACCESS && r_cnt == 4'd0;
  assign busy     = w_start || r_state == ACCESS;
  assign rdata    = r_rdata;
  // Byte-offset and wrap-around address bits are intentionally ignored.
  assign w_unused = &{1'b0, addr[31:ADDR_WIDTH+2], addr[1:0]};
  always_ff @(posedge clk)
    if (!reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_last_pc <= 32'd0;
      r_rdata   <= 32'd0;
    end else if (w_start) begin
      r_state <= ACCESS;
      r_cnt   <= 4'(LATENCY - 1);
      r_word  <= addr[ADDR_WIDTH+1:2];
      r_wdata <= wdata;
      r_be    <= be;
      r_pc    <= pc;
      r_wr    <= memwrite;
    end else if (w_commit) begin
      r_state   <= IDLE;
      r_last_pc <= r_pc;
      if (!r_wr) r_rdata <= r_mem[r_word];
    end else if (r_state == ACCESS)
      r_cnt <= r_cnt - 4'd1;
  // RAM is never reset; a reset during ACCESS suppresses the pending write.
  always_ff @(posedge clk)
    if (reset && w_commit && r_wr)
      for (int i = 0; i < 4; i++)
        if (r_be[i]) r_mem[r_word][8*i +: 8] <= r_wdata[8*i +: 8];
endmodule

// File: tb/tb_dm_wait_responder.sv
// tb_dm_wait_responder: directed bench with a transaction-level model checked every cycle.
module tb_dm_wait_responder;
  localparam int AW  = 10;
  localparam int LAT = 2;
  logic        clk = 0;
  logic        reset = 0;
  logic [31:0] pc = 0, addr = 0, wdata = 0, rdata;
  logic        memread = 0, memwrite = 0, busy;
  logic [3:0]  be = 0;
  int          checks = 0, errors = 0, n;

  dm_wait_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .pc(pc), .memread(memread), .memwrite(memwrite),
    .addr(addr), .wdata(wdata), .be(be), .rdata(rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an access keeps busy high for LAT+1 cycles and takes effect at the end of the last one.
  int          m_rem = 0;
  logic        m_on = 0, m_known = 1;
  logic [31:0] m_last = 0, m_rdata = 0, t_pc = 0, t_data = 0;
  logic [AW-1:0] t_word = 0;
  logic [3:0]  t_be = 0;
  logic        t_wr = 0;
  logic [31:0] m_mem [1<<AW];
  bit          m_vld [1<<AW];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] b);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_on <= 1; m_rem <= 0; m_last <= 0; m_rdata <= 0; m_known <= 1;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_last <= t_pc;
        if (t_wr) begin
          m_mem[t_word] <= merge(m_mem[t_word], t_data, t_be);
          m_vld[t_word] <= m_vld[t_word] | (t_be == 4'hF);
        end else begin
          m_rdata <= m_mem[t_word];
          m_known <= m_vld[t_word];
        end
      end
    end else if ((memread || memwrite) && pc != m_last) begin
      m_rem <= LAT; t_pc <= pc; t_wr <= memwrite; t_data <= wdata; t_be <= be;
      t_word <= addr[AW+1:2];
    end
  end

  always @(negedge clk)
    if (m_on) begin
      chk("model_busy", {31'd0, busy}, {31'd0, m_rem > 0 || ((memread || memwrite) && pc != m_last)});
      if (m_known) chk("model_rdata", rdata, m_rdata);
    end

  // Called at a negedge; presents a request and counts consecutive busy cycles.
  task automatic access(input logic [31:0] p, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] b, input logic drop, output int cnt);
    #1;
    pc = p; memread = r; memwrite = w; addr = a; wdata = d; be = b; cnt = 0;
    #1;
    while (busy && cnt < 20) begin
      cnt++;
      @(negedge clk);
      if (drop && cnt == 1) begin
        #1; memread = 0; memwrite = 0; wdata = 0; addr = 0;
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 1;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rdata", rdata, 32'h0);
    access(32'h100, 0, 1, 32'h40, 32'hDEADBEEF, 4'hF, 0, n);
    chk("store_busy_len", 32'(n), 32'd3);
    access(32'h104, 1, 0, 32'h40, 32'h0, 4'h0, 0, n);
    chk("load_busy_len", 32'(n), 32'd3);
    chk("load_data", rdata, 32'hDEADBEEF);
    access(32'h108, 0, 1, 32'h40, 32'h00000011, 4'b0001, 0, n);
    access(32'h10C, 1, 0, 32'h40, 32'h0, 4'h0, 0, n);
    chk("byte_enable", rdata, 32'hDEADBE11);
    repeat (5) begin
      @(negedge clk);
      chk("held_no_restart", {31'd0, busy}, 32'd0);
    end
    access(32'h200, 1, 0, 32'h40, 32'h0, 4'h0, 0, n);
    chk("new_pc_busy_len", 32'(n), 32'd3);
    chk("new_pc_data", rdata, 32'hDEADBE11);
    access(32'h500, 0, 1, 32'h44, 32'h01020304, 4'hF, 1, n);
    chk("dropped_req_len", 32'(n), 32'd3);
    access(32'h504, 1, 0, 32'h44, 32'h0, 4'h0, 0, n);
    chk("dropped_req_data", rdata, 32'h01020304);
    access(32'h2F0, 0, 1, 32'h80, 32'h55555555, 4'hF, 0, n);
    #1;
    pc = 32'h300; memread = 0; memwrite = 1; addr = 32'h80; wdata = 32'h12345678; be = 4'hF;
    @(negedge clk);
    chk("abort_second_busy", {31'd0, busy}, 32'd1);
    #1 reset = 0; memwrite = 0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rdata", rdata, 32'h0);
    #1 reset = 1;
    @(negedge clk);
    access(32'h304, 1, 0, 32'h80, 32'h0, 4'h0, 0, n);
    checks++;
    if (rdata === 32'h12345678) begin
      errors++;
      $display("FAIL abort_no_write: got %h required anything but 12345678", rdata);
    end
    chk("abort_old_data", rdata, 32'h55555555);
    access(32'h400, 1, 1, 32'h1040, 32'hA5A5A5A5, 4'hF, 0, n);
    chk("rw_busy_len", 32'(n), 32'd3);
    chk("rw_is_write", rdata, 32'h55555555);
    access(32'h404, 1, 0, 32'h40, 32'h0, 4'h0, 0, n);
    chk("wrap_data", rdata, 32'hA5A5A5A5);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
